// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the pipeline stage registers and the hazard logic
// that inspects them.
//   - control-bundle bit positions (RegWrite, MemWrite, MemToReg, JAL, LUI,
//     LB, branch field, ALU-op field)
//   - default per-stage widths for IF/ID, ID/EX, EX/MEM and MEM/WB
//   - pipe_op_e, the per-cycle action of a stage register
//   - ctrl_is_write(), which tells a hazard unit whether an entry writes state
package pipe_pkg;

  // Control-bundle bit map, shared by every stage that carries the bundle.
  localparam int unsigned CTRL_REGWRITE   = 0;
  localparam int unsigned CTRL_MEMWRITE   = 1;
  localparam int unsigned CTRL_MEMTOREG   = 2;
  localparam int unsigned CTRL_JAL        = 3;
  localparam int unsigned CTRL_LUI        = 4;
  localparam int unsigned CTRL_LB         = 5;
  localparam int unsigned CTRL_BRANCH_LSB = 6;
  localparam int unsigned CTRL_BRANCH_MSB = 8;
  localparam int unsigned CTRL_ALUOP_LSB  = 9;
  localparam int unsigned CTRL_ALUOP_MSB  = 12;

  // Common widths
  localparam int unsigned PIPE_RW_W   = 5;
  localparam int unsigned PIPE_DATA_W = 32;

  // IF/ID: no decoded control yet; carries instruction word and PC.
  localparam int unsigned IFID_CTRL_W  = 1;
  localparam int unsigned IFID_NDATA   = 2;

  // ID/EX: A, B, Ext, Imm, PC, index.
  localparam int unsigned IDEX_CTRL_W  = 24;
  localparam int unsigned IDEX_NDATA   = 6;

  // EX/MEM: ALU result, store data, PC.
  localparam int unsigned EXMEM_CTRL_W = 16;
  localparam int unsigned EXMEM_NDATA  = 3;

  // MEM/WB: ALU result, load data.
  localparam int unsigned MEMWB_CTRL_W = 8;
  localparam int unsigned MEMWB_NDATA  = 2;

  // What a stage register does on the coming edge (reset handled separately).
  typedef enum logic [1:0] {
    PIPE_OP_LOAD  = 2'd0,
    PIPE_OP_HOLD  = 2'd1,
    PIPE_OP_FLUSH = 2'd2
  } pipe_op_e;

  // True when the entry would update architectural state (register file or
  // memory). Narrower bundles are zero-extended by the caller.
  function automatic logic ctrl_is_write(input logic [IDEX_CTRL_W-1:0] ctrl);
    return ctrl[CTRL_REGWRITE] | ctrl[CTRL_MEMWRITE];
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// sat_cnt
// Saturating up-counter with synchronous clear.
//   clk  : clock, posedge
//   rst  : synchronous active-high reset, counter to zero
//   inc  : advance by one unless already at MAX
//   clr  : return to zero (takes priority over inc)
//   cnt  : current count
module sat_cnt #(
  parameter int unsigned      W   = 8,
  parameter logic [W-1:0]     MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Fully registered pipeline stage boundary with stall, flush and valid.
// Optional statistics counters are built when PIPE_STATS_EN is defined;
// otherwise stall_cnt_o / flush_cnt_o are tied to zero.
//
// Ports
//   clk          clock, posedge
//   rst          synchronous active-high reset
//   stall_i      hold current contents
//   flush_i      insert a bubble (wins over stall_i)
//   valid_i      upstream entry is a real instruction
//   ctrl_i       control bundle        [CTRL_W]
//   rw_i         destination register  [RW_W]
//   data_i       packed data words     [NDATA*DATA_W], word k at [k*DATA_W +: DATA_W]
//   valid_o      registered valid
//   ctrl_o       registered control, zero whenever valid_o=0
//   rw_o         registered destination, zero whenever valid_o=0
//   data_o       registered data (held across flushes)
//   bubble_o     current entry was created by a flush
//   stall_to_o   STALL_MAX or more consecutive stalled cycles
//   stall_cnt_o  total stalled cycles (PIPE_STATS_EN)
//   flush_cnt_o  total flush cycles (PIPE_STATS_EN)
//
// STALL_MAX must be at least 1.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W    = IDEX_CTRL_W,
  parameter int unsigned RW_W      = PIPE_RW_W,
  parameter int unsigned DATA_W    = PIPE_DATA_W,
  parameter int unsigned NDATA     = IDEX_NDATA,
  parameter int unsigned STALL_MAX = 15,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic                    valid_i,
  input  logic [CTRL_W-1:0]       ctrl_i,
  input  logic [RW_W-1:0]         rw_i,
  input  logic [NDATA*DATA_W-1:0] data_i,
  output logic                    valid_o,
  output logic [CTRL_W-1:0]       ctrl_o,
  output logic [RW_W-1:0]         rw_o,
  output logic [NDATA*DATA_W-1:0] data_o,
  output logic                    bubble_o,
  output logic                    stall_to_o,
  output logic [CNT_W-1:0]        stall_cnt_o,
  output logic [CNT_W-1:0]        flush_cnt_o
);

  localparam int unsigned          SCNT_W   = $clog2(STALL_MAX + 1);
  localparam logic [SCNT_W-1:0]    SCNT_MAX = SCNT_W'(STALL_MAX);

  pipe_op_e          op;
  logic              stall_eff;
  logic              stall_clr;
  logic [SCNT_W-1:0] scnt;

  // A stall that coincides with a flush is not a stall: the flush discards
  // the held entry, so it neither holds the register nor counts as stalled.
  assign stall_eff = stall_i & ~flush_i;
  assign stall_clr = ~stall_eff;

  always_comb begin
    if (flush_i) begin
      op = PIPE_OP_FLUSH;
    end else if (stall_i) begin
      op = PIPE_OP_HOLD;
    end else begin
      op = PIPE_OP_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o  <= 1'b0;
      ctrl_o   <= '0;
      rw_o     <= '0;
      data_o   <= '0;
      bubble_o <= 1'b0;
    end else begin
      case (op)
        PIPE_OP_LOAD: begin
          valid_o  <= valid_i;
          // Mask control of invalid entries so no write/branch bit leaks.
          ctrl_o   <= valid_i ? ctrl_i : '0;
          rw_o     <= valid_i ? rw_i   : '0;
          data_o   <= data_i;
          bubble_o <= 1'b0;
        end
        PIPE_OP_FLUSH: begin
          // data_o deliberately kept: it is dead once valid_o drops, and
          // holding it avoids toggling the wide data bus.
          valid_o  <= 1'b0;
          ctrl_o   <= '0;
          rw_o     <= '0;
          bubble_o <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Consecutive-stall watchdog; saturating at STALL_MAX keeps it sticky for
  // arbitrarily long stalls without a wide counter.
  sat_cnt #(
    .W   (SCNT_W),
    .MAX (SCNT_MAX)
  ) u_wdog (
    .clk (clk),
    .rst (rst),
    .inc (stall_eff),
    .clr (stall_clr),
    .cnt (scnt)
  );

  assign stall_to_o = (scnt >= SCNT_MAX);

`ifdef PIPE_STATS_EN
  sat_cnt #(
    .W (CNT_W)
  ) u_stall_stat (
    .clk (clk),
    .rst (rst),
    .inc (stall_eff),
    .clr (1'b0),
    .cnt (stall_cnt_o)
  );

  sat_cnt #(
    .W (CNT_W)
  ) u_flush_stat (
    .clk (clk),
    .rst (rst),
    .inc (flush_i),
    .clr (1'b0),
    .cnt (flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
// Directed steps followed by randomized traffic, each edge checked against a
// behavioural model of the stage (expected outputs, stall run length, event
// totals). Statistics expectations follow PIPE_STATS_EN.
module tb_pipe_stage_reg;

  localparam int CTRL_W    = 24;
  localparam int RW_W      = 5;
  localparam int DATA_W    = 32;
  localparam int NDATA     = 6;
  localparam int STALL_MAX = 4;
  localparam int CNT_W     = 32;
  localparam int DW        = NDATA * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall_i, flush_i, valid_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic [RW_W-1:0]   rw_i;
  logic [DW-1:0]     data_i;
  logic              valid_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [RW_W-1:0]   rw_o;
  logic [DW-1:0]     data_o;
  logic              bubble_o;
  logic              stall_to_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .CTRL_W    (CTRL_W),
    .RW_W      (RW_W),
    .DATA_W    (DATA_W),
    .NDATA     (NDATA),
    .STALL_MAX (STALL_MAX),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .ctrl_i      (ctrl_i),
    .rw_i        (rw_i),
    .data_i      (data_i),
    .valid_o     (valid_o),
    .ctrl_o      (ctrl_o),
    .rw_o        (rw_o),
    .data_o      (data_o),
    .bubble_o    (bubble_o),
    .stall_to_o  (stall_to_o),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );

  // reference model state
  logic              m_valid, m_bubble;
  logic [CTRL_W-1:0] m_ctrl;
  logic [RW_W-1:0]   m_rw;
  logic [DW-1:0]     m_data;
  int                m_stall_run;
  longint            m_stall_total, m_flush_total;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic longint sat_total(input longint n);
    longint lim;
    lim = (longint'(1) <<< CNT_W) - 1;
    return (n > lim) ? lim : n;
  endfunction

  task automatic check_all(input string tag);
    logic [CNT_W-1:0] e_sc, e_fc;
`ifdef PIPE_STATS_EN
    e_sc = CNT_W'(sat_total(m_stall_total));
    e_fc = CNT_W'(sat_total(m_flush_total));
`else
    e_sc = '0;
    e_fc = '0;
`endif
    chk({tag, ".valid"},    DW'(valid_o),     DW'(m_valid));
    chk({tag, ".ctrl"},     DW'(ctrl_o),      DW'(m_ctrl));
    chk({tag, ".rw"},       DW'(rw_o),        DW'(m_rw));
    chk({tag, ".data"},     data_o,           m_data);
    chk({tag, ".bubble"},   DW'(bubble_o),    DW'(m_bubble));
    chk({tag, ".stall_to"}, DW'(stall_to_o),  DW'(m_stall_run >= STALL_MAX));
    chk({tag, ".stall_cnt"}, DW'(stall_cnt_o), DW'(e_sc));
    chk({tag, ".flush_cnt"}, DW'(flush_cnt_o), DW'(e_fc));
  endtask

  // One clock edge: apply the stage rules to whatever is driven at the edge,
  // then sample the DUT 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_ctrl = '0; m_rw = '0; m_data = '0; m_bubble = 0;
      m_stall_run = 0; m_stall_total = 0; m_flush_total = 0;
    end else begin
      if (flush_i) begin
        m_valid = 0; m_ctrl = '0; m_rw = '0; m_bubble = 1;
        m_flush_total++;
      end else if (!stall_i) begin
        m_valid  = valid_i;
        m_ctrl   = valid_i ? ctrl_i : '0;
        m_rw     = valid_i ? rw_i : '0;
        m_data   = data_i;
        m_bubble = 0;
      end
      if (stall_i && !flush_i) begin
        m_stall_run++;
        m_stall_total++;
      end else begin
        m_stall_run = 0;
      end
    end
    #1;
    check_all(tag);
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < NDATA; k++) d[k*DATA_W +: DATA_W] = $urandom;
    return d;
  endfunction

  task automatic drive_rand();
    valid_i = ($urandom_range(0, 9) < 8);
    ctrl_i  = CTRL_W'($urandom);
    rw_i    = RW_W'($urandom);
    data_i  = rand_data();
  endtask

  initial begin
    logic [DW-1:0] held;
    rst = 1; stall_i = 0; flush_i = 0; valid_i = 0;
    ctrl_i = '0; rw_i = '0; data_i = '0;
    m_valid = 0; m_ctrl = '0; m_rw = '0; m_data = '0; m_bubble = 0;
    m_stall_run = 0; m_stall_total = 0; m_flush_total = 0;

    // reset
    step("reset0");
    step("reset1");
    rst = 0;

    // plain load
    valid_i = 1; ctrl_i = 24'h0000A5; rw_i = 5'd9;
    data_i = rand_data();
    data_i[DATA_W-1:0] = 32'h1234_5678;
    step("load");
    chk("load.word0", DW'(data_o[DATA_W-1:0]), DW'(32'h1234_5678));
    chk("load.ctrl_const", DW'(ctrl_o), DW'(24'h0000A5));
    held = data_o;

    // stall hold for 3 cycles with changing inputs
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      step("stall");
    end
    chk("stall.rw_const", DW'(rw_o), DW'(5'd9));
    chk("stall.data_held", data_o, held);
    chk("stall.no_to", DW'(stall_to_o), DW'(1'b0));
    stall_i = 0;
    drive_rand(); valid_i = 1;
    step("release");

    // flush beats stall
    held = data_o;
    stall_i = 1; flush_i = 1; drive_rand();
    step("flush_stall");
    chk("flush_stall.bubble", DW'(bubble_o), DW'(1'b1));
    chk("flush_stall.data_held", data_o, held);
    stall_i = 0; flush_i = 0;

    // invalid input masked
    valid_i = 0; ctrl_i = 24'hFF_FFFF; rw_i = 5'd31; data_i = rand_data();
    step("invalid");
    chk("invalid.ctrl_zero", DW'(ctrl_o), '0);

    // watchdog: 6 stalled cycles, rises after the 4th
    stall_i = 1;
    for (int i = 1; i <= 6; i++) begin
      drive_rand();
      step("wdog");
      chk("wdog.edge", DW'(stall_to_o), DW'(i >= STALL_MAX));
    end
    stall_i = 0;
    step("wdog_release");
    chk("wdog.cleared", DW'(stall_to_o), DW'(1'b0));

    // long stall keeps the watchdog asserted (saturation)
    stall_i = 1;
    for (int i = 0; i < 20; i++) step("wdog_long");
    chk("wdog_long.high", DW'(stall_to_o), DW'(1'b1));
    flush_i = 1;
    step("wdog_flush_clear");
    chk("wdog_flush.cleared", DW'(stall_to_o), DW'(1'b0));
    flush_i = 0; stall_i = 0;

    // statistics from a clean reset, then reset during a stall
    rst = 1; step("stats_rst"); rst = 0;
    stall_i = 1;
    for (int i = 0; i < 5; i++) step("stats_stall");
    stall_i = 0; flush_i = 1;
    for (int i = 0; i < 2; i++) step("stats_flush");
    flush_i = 0;
`ifdef PIPE_STATS_EN
    chk("stats.stall5", DW'(stall_cnt_o), DW'(5));
    chk("stats.flush2", DW'(flush_cnt_o), DW'(2));
`else
    chk("stats.stall_tied", DW'(stall_cnt_o), DW'(0));
    chk("stats.flush_tied", DW'(flush_cnt_o), DW'(0));
`endif
    valid_i = 1; drive_rand(); valid_i = 1;
    step("stats_load");
    stall_i = 1; rst = 1;
    step("rst_during_stall");
    chk("rst_stall.valid", DW'(valid_o), DW'(1'b0));
    chk("rst_stall.data", data_o, '0);
    rst = 0; stall_i = 0;

    // reset pulse between edges has no effect
    drive_rand(); valid_i = 1;
    step("pre_glitch");
    held = data_o;
    @(negedge clk);
    rst = 1; #2; rst = 0;
    stall_i = 1;
    step("rst_glitch");
    chk("rst_glitch.data", data_o, held);
    stall_i = 0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive_rand();
      stall_i = ($urandom_range(0, 9) < 4);
      flush_i = ($urandom_range(0, 9) == 0);
      rst     = ($urandom_range(0, 99) < 2);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, fully registered pipeline stage register that succeeds the combinational ID/EX passthrough. It captures a control bundle, a destination register index and N data words on each clock, and supports stall (hold), flush (bubble insertion) and a per-entry valid bit. One instance sits at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB), with CTRL_W and NDATA sized per stage. Optional counters collect stall and flush statistics.

## Interface
- CTRL_W, 24: width of the control bundle (RegWrite, MemWrite, MemToReg, ALUOP, branch/jump bits, …).
- RW_W, 5: width of the destination register index.
- DATA_W, 32: width of one data word.
- NDATA, 6: number of data words (ID/EX: A, B, Ext, Imm, PC, index).
- STALL_MAX, 15: consecutive-stall cycle count at which the watchdog fires. Must be ≥1.
- CNT_W, 32: statistics counter width. Used only with PIPE_STATS_EN.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  hold the current contents.
- flush_i  in  1  insert a bubble.
- valid_i  in  1  upstream entry is a real instruction.
- ctrl_i  in  CTRL_W  control bundle.
- rw_i  in  RW_W  destination register.
- data_i  in  NDATA*DATA_W  packed data words; word k is at bits [k*DATA_W +: DATA_W].
- valid_o  out  1  registered valid.
- ctrl_o  out  CTRL_W  registered control; zero whenever valid_o=0.
- rw_o  out  RW_W  registered destination; zero whenever valid_o=0.
- data_o  out  NDATA*DATA_W  registered data.
- bubble_o  out  1  current entry was created by a flush.
- stall_to_o  out  1  the stall watchdog has fired.
- stall_cnt_o  out  CNT_W  total stalled cycles (PIPE_STATS_EN only).
- flush_cnt_o  out  CNT_W  total flush cycles (PIPE_STATS_EN only).

## Operation
- Per-cycle priority: rst > flush_i > stall_i > load.
- **Load** (no stall, no flush):
  - valid_o ← valid_i.
  - ctrl_o ← valid_i ? ctrl_i : 0.
  - rw_o ← valid_i ? rw_i : 0.
  - data_o ← data_i.
  - bubble_o ← 0.
- **Stall:** every output register holds its value. A stall never drops or duplicates an entry.
- **Flush:** valid_o ← 0, ctrl_o ← 0, rw_o ← 0, bubble_o ← 1. data_o holds its previous value.
- **Flush and stall together:** flush wins. The bubble is inserted and the stalled entry is discarded.
- Zeroed control guarantees that no RegWrite, MemWrite or branch bit escapes from an invalid entry.
- **Stall watchdog:** a saturating counter scnt.
  - Increments on each stalled cycle.
  - Clears on any cycle without a stall, including a flush cycle.
  - stall_to_o = (scnt ≥ STALL_MAX). It is sticky until the first non-stall cycle.
  - scnt saturates at STALL_MAX.

## Timing
- Latency is one cycle: inputs sampled at edge n appear on the outputs after edge n.
- There are no combinational paths from inputs to outputs.
- Reset values: valid_o=0, ctrl_o=0, rw_o=0, data_o=0, bubble_o=0, stall_to_o=0, scnt=0, stall_cnt_o=0, flush_cnt_o=0.
- Reset asserted during a stall or flush: the next edge gives the reset values, and stall/flush are ignored on that edge.
- Reset has no effect between edges.
- stall_to_o rises on the edge that completes the STALL_MAX-th consecutive stalled cycle, and falls on the edge after the first unstalled cycle.
- Counters saturate at 2^CNT_W−1 and never wrap.

## Configuration
- Macro: PIPE_STATS_EN.
- **Defined:**
  - stall_cnt_o increments on every cycle with stall_i=1 and flush_i=0.
  - flush_cnt_o increments on every cycle with flush_i=1.
  - Both are zero after reset and saturate at 2^CNT_W−1.
- **Undefined:** both ports are still present but tied to 0, and no counter flops are built.

## Structure
- Shared package pipe_pkg holds:
  - Control-bit index constants (CTRL_REGWRITE, CTRL_MEMWRITE, CTRL_MEMTOREG, CTRL_JAL, CTRL_LUI, CTRL_LB, CTRL_BRANCH range, CTRL_ALUOP range).
  - Default stage widths (IDEX_CTRL_W, IDEX_NDATA, and so on).
  - Function ctrl_is_write() for hazard units.
- One sub-module, sat_cnt, a parametrised-width saturating counter with inc and clr inputs.
  - The stall watchdog and both statistics counters each instantiate sat_cnt.

## Test plan
- **Load:** reset, then valid_i=1, ctrl_i=24'h00_0A5, rw_i=5'd9, data word0=32'h1234_5678. After one edge: valid_o=1, ctrl_o=24'h00_0A5, rw_o=9, word0=32'h1234_5678, bubble_o=0.
- **Stall hold:** load value X, then assert stall_i for 3 cycles while driving different inputs. Outputs stay X. On release, the next input loads after one edge.
- **Flush beats stall:** with stall_i=1 and flush_i=1 for one edge: valid_o=0, ctrl_o=0, rw_o=0, bubble_o=1, data_o unchanged.
- **Invalid input masked:** valid_i=0 with ctrl_i=24'hFF_FFFF and rw_i=31. After one edge: ctrl_o=0, rw_o=0, valid_o=0, bubble_o=0.
- **Watchdog:** with STALL_MAX=4, hold stall_i high for 6 cycles. stall_to_o rises after the 4th edge and stays high through the 6th. Drop stall_i: stall_to_o clears after the next edge.
- **Statistics and mid-run reset** (PIPE_STATS_EN defined): 5 stall cycles and 2 flush cycles give stall_cnt_o=5 and flush_cnt_o=2. Then assert rst in the same cycle as a stall: all outputs return to zero after that edge.
